// File: rtl/data_memory_arbiter_if.sv
// Bus between the two data-memory requesters, the arbiter and the data memory.
interface data_memory_arbiter_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  Req0, Req1;
  logic                  We0, We1;
  logic [ADDR_WIDTH-1:0] Addr0, Addr1;
  logic [31:0]           Wdata0, Wdata1;
  logic                  Ack0, Ack1;
  logic [31:0]           Rdata0, Rdata1;
  logic [ADDR_WIDTH-1:0] MemAddress;
  logic [31:0]           MemWriteData;
  logic                  MemoryRead, MemoryWrite;
  logic [31:0]           MemReadData;
  logic                  Busy;

  // Requesters and the memory drive requests / read data and observe the arbiter
  modport master (
    output Req0, Req1, We0, We1, Addr0, Addr1, Wdata0, Wdata1, MemReadData,
    input  Ack0, Ack1, Rdata0, Rdata1, MemAddress, MemWriteData,
           MemoryRead, MemoryWrite, Busy
  );

  // The arbiter itself
  modport slave (
    input  Req0, Req1, We0, We1, Addr0, Addr1, Wdata0, Wdata1, MemReadData,
    output Ack0, Ack1, Rdata0, Rdata1, MemAddress, MemWriteData,
           MemoryRead, MemoryWrite, Busy
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter in front of a single-port data memory.
// Each access takes IDLE -> GRANT -> DONE: the memory is driven during GRANT,
// the winner is acknowledged (with read data passed through) during DONE.
module data_memory_arbiter #(
  parameter int ADDR_WIDTH     = 6,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input logic                  Clock,
  input logic                  Reset_n,
  data_memory_arbiter_if.slave bus
);
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, DONE = 2'd2} state_t;

  state_t                state_q, state_d;
  logic                  take;
  logic                  win;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_wdata;

  logic                  last_q;
  logic                  idx_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;
  logic                  mem_rd_q, mem_wr_q;
  logic                  ack0_q, ack1_q;

  // Next state and winner selection; requests are looked at only in IDLE
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    win     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Req0 || bus.Req1) begin
          take    = 1'b1;
          state_d = GRANT;
          if (bus.Req0 && bus.Req1) win = FIXED_PRIORITY ? 1'b0 : ~last_q;
          else                      win = bus.Req1;
        end
      end
      GRANT:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sel_we    = win ? bus.We1    : bus.We0;
  assign sel_addr  = win ? bus.Addr1  : bus.Addr0;
  assign sel_wdata = win ? bus.Wdata1 : bus.Wdata0;

  // State register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Winner bookkeeping: index and direction survive until the Ack in DONE;
  // LastGrant resets to 1 so requester 0 wins the first tie
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      last_q <= 1'b1;
      idx_q  <= 1'b0;
      we_q   <= 1'b0;
    end else if (take) begin
      last_q <= win;
      idx_q  <= win;
      we_q   <= sel_we;
    end
  end

  // Memory-side registers hold the latched address/data only for the GRANT
  // cycle and are zero otherwise; the async clear aborts a write before the
  // memory's negedge commit
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      mem_addr_q  <= take ? sel_addr  : '0;
      mem_wdata_q <= take ? sel_wdata : '0;
      mem_rd_q    <= take & ~sel_we;
      mem_wr_q    <= take &  sel_we;
    end
  end

  // One-cycle completion strobe to the latched winner on entry to DONE
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
    end else begin
      ack0_q <= (state_q == GRANT) && !idx_q;
      ack1_q <= (state_q == GRANT) &&  idx_q;
    end
  end

  assign bus.MemAddress   = mem_addr_q;
  assign bus.MemWriteData = mem_wdata_q;
  assign bus.MemoryRead   = mem_rd_q;
  assign bus.MemoryWrite  = mem_wr_q;
  assign bus.Ack0         = ack0_q;
  assign bus.Ack1         = ack1_q;
  // Memory read data is passed straight through only during a read Ack
  assign bus.Rdata0       = (ack0_q && !we_q) ? bus.MemReadData : '0;
  assign bus.Rdata1       = (ack1_q && !we_q) ? bus.MemReadData : '0;
  assign bus.Busy         = (state_q != IDLE);
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: a round-robin instance exercised
// with directed and random traffic against a data-memory model, plus a
// fixed-priority instance for the priority scenario.
module tb_data_memory_arbiter;
  logic Clock;
  logic Reset_n;

  data_memory_arbiter_if #(.ADDR_WIDTH(6)) bus ();
  data_memory_arbiter_if #(.ADDR_WIDTH(6)) fbus ();

  data_memory_arbiter #(.ADDR_WIDTH(6), .FIXED_PRIORITY(1'b0)) u_dut (
    .Clock(Clock), .Reset_n(Reset_n), .bus(bus)
  );
  data_memory_arbiter #(.ADDR_WIDTH(6), .FIXED_PRIORITY(1'b1)) u_fix (
    .Clock(Clock), .Reset_n(Reset_n), .bus(fbus)
  );

  typedef struct { int idx; logic [31:0] rdata; int cyc; } ack_t;
  typedef struct { logic we; logic [5:0] addr; logic [31:0] wdata; int cyc; } op_t;

  ack_t        sq[$];
  op_t         mq[$];
  int          ack_log[$];
  logic [31:0] mem    [64];
  logic [31:0] shadow [64];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          last;
  bit          pend [2];
  logic        twe  [2];
  logic [5:0]  taddr[2];
  logic [31:0] twd  [2];
  logic [31:0] last_rdata;
  ack_t        ma;
  op_t         mo;
  int          midx;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cyc <= cyc + 1;

  // Data memory: writes commit on the negedge, reads capture on the posedge
  always @(negedge Clock) if (bus.MemoryWrite) mem[bus.MemAddress] = bus.MemWriteData;
  always @(posedge Clock) if (bus.MemoryRead) bus.MemReadData <= mem[bus.MemAddress];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},   32'(bus.Busy),        32'd0);
    chk({tag, "_mrd"},    32'(bus.MemoryRead),  32'd0);
    chk({tag, "_mwr"},    32'(bus.MemoryWrite), 32'd0);
    chk({tag, "_ack0"},   32'(bus.Ack0),        32'd0);
    chk({tag, "_ack1"},   32'(bus.Ack1),        32'd0);
    chk({tag, "_rdata0"}, bus.Rdata0,           32'd0);
    chk({tag, "_rdata1"}, bus.Rdata1,           32'd0);
    chk({tag, "_maddr"},  32'(bus.MemAddress),  32'd0);
    chk({tag, "_mwdata"}, bus.MemWriteData,     32'd0);
  endtask

  // Monitor: every memory operation and every Ack is matched against the queues
  always @(negedge Clock) begin
    if (Reset_n) begin
      chk("enables_onehot", 32'(bus.MemoryRead & bus.MemoryWrite), 32'd0);
      chk("acks_onehot", 32'(bus.Ack0 & bus.Ack1), 32'd0);
      if (bus.MemoryRead || bus.MemoryWrite) begin
        chk("busy_grant", 32'(bus.Busy), 32'd1);
        if (mq.size() == 0) chk("unexpected_mem_op", 32'd1, 32'd0);
        else begin
          mo = mq.pop_front();
          chk("mem_we", 32'(bus.MemoryWrite), 32'(mo.we));
          chk("mem_addr", 32'(bus.MemAddress), 32'(mo.addr));
          if (mo.we) chk("mem_wdata", bus.MemWriteData, mo.wdata);
          chk("mem_cycle", cyc, mo.cyc);
        end
      end else begin
        chk("maddr_idle", 32'(bus.MemAddress), 32'd0);
        chk("mwdata_idle", bus.MemWriteData, 32'd0);
      end
      if (bus.Ack0 || bus.Ack1) begin
        chk("busy_done", 32'(bus.Busy), 32'd1);
        midx = bus.Ack1 ? 1 : 0;
        if (sq.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
        else begin
          ma = sq.pop_front();
          last_rdata = midx ? bus.Rdata1 : bus.Rdata0;
          chk("ack_idx", midx, ma.idx);
          chk("rdata", last_rdata, ma.rdata);
          chk("rdata_other", midx ? bus.Rdata0 : bus.Rdata1, 32'd0);
          chk("ack_cycle", cyc, ma.cyc);
          ack_log.push_back(midx);
        end
      end else begin
        chk("rdata_idle", bus.Rdata0 | bus.Rdata1, 32'd0);
      end
    end
  end

  task automatic drive(input int i, input logic r, input logic we, input logic [5:0] a,
                       input logic [31:0] d);
    if (i == 0) begin
      bus.Req0 = r; bus.We0 = we; bus.Addr0 = a; bus.Wdata0 = d;
    end else begin
      bus.Req1 = r; bus.We1 = we; bus.Addr1 = a; bus.Wdata1 = d;
    end
  endtask

  task automatic load(input int i, input logic we, input logic [5:0] a, input logic [31:0] d);
    pend[i] = 1'b1; twe[i] = we; taddr[i] = a; twd[i] = d;
    drive(i, 1'b1, we, a, d);
  endtask

  // One arbitration slot, entered on a negedge while the arbiter is idle and
  // left on the negedge of the next idle cycle (3 cycles per granted access)
  task automatic run_round(input bit keep, input bit tweak);
    int w;
    int c0;
    if (!pend[0] && !pend[1]) begin
      @(negedge Clock);
      return;
    end
    if (pend[0] && pend[1]) w = 1 - last;
    else                    w = pend[0] ? 0 : 1;
    last = w;
    c0 = cyc;
    mq.push_back('{we: twe[w], addr: taddr[w], wdata: twd[w], cyc: c0 + 1});
    if (twe[w]) begin
      shadow[taddr[w]] = twd[w];
      sq.push_back('{idx: w, rdata: 32'd0, cyc: c0 + 2});
    end else begin
      sq.push_back('{idx: w, rdata: shadow[taddr[w]], cyc: c0 + 2});
    end
    @(negedge Clock);
    if (tweak) drive(w, 1'b1, twe[w], 6'd9, twd[w]);
    @(negedge Clock);
    if (!keep) begin
      pend[w] = 1'b0;
      drive(w, 1'b0, 1'b0, 6'd0, 32'd0);
    end
    @(negedge Clock);
  endtask

  initial begin
    int n0, n1, got;
    for (int i = 0; i < 64; i++) begin
      mem[i]    = 32'hC0DE0000 | 32'(i);
      shadow[i] = 32'hC0DE0000 | 32'(i);
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive(0, 1'b0, 1'b0, 6'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 6'd0, 32'd0);
    fbus.Req0 = 1'b0; fbus.Req1 = 1'b0; fbus.We0 = 1'b0; fbus.We1 = 1'b0;
    fbus.Addr0 = 6'd1; fbus.Addr1 = 6'd2; fbus.Wdata0 = 32'd0; fbus.Wdata1 = 32'd0;
    fbus.MemReadData = 32'd0;
    bus.MemReadData = 32'd0;
    Reset_n = 1'b1;
    #2 Reset_n = 1'b0;

    // Reset state
    repeat (3) @(negedge Clock);
    chk_quiet("reset");
    Reset_n = 1'b1;
    last = 1;

    // Idle quiescence
    repeat (20) begin
      @(negedge Clock);
      chk_quiet("idle");
    end

    // Write then read back the same word
    load(0, 1'b1, 6'd5, 32'hDEADBEEF);
    run_round(1'b0, 1'b0);
    load(0, 1'b0, 6'd5, 32'd0);
    run_round(1'b0, 1'b0);
    chk("wr_rd_addr5", last_rdata, 32'hDEADBEEF);

    // Address change while the access is in flight
    load(1, 1'b0, 6'd3, 32'd0);
    run_round(1'b0, 1'b1);
    chk("attr_change_rdata", last_rdata, 32'hC0DE0003);

    // Random traffic
    for (int r = 0; r < 150; r++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 2) != 0)
          load(i, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), $urandom);
      run_round($urandom_range(0, 3) == 0, 1'b0);
    end
    while (pend[0] || pend[1]) run_round(1'b0, 1'b0);

    // Asynchronous reset in the middle of a write
    load(0, 1'b1, 6'd7, 32'h0BADF00D);
    run_round(1'b0, 1'b0);
    drive(0, 1'b1, 1'b1, 6'd7, 32'h12345678);
    @(posedge Clock);
    #1;
    chk("pre_abort_mwr", 32'(bus.MemoryWrite), 32'd1);
    chk("pre_abort_maddr", 32'(bus.MemAddress), 32'd7);
    Reset_n = 1'b0;
    #1;
    chk_quiet("async_rst");
    drive(0, 1'b0, 1'b0, 6'd0, 32'd0);
    @(negedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
    last = 1;

    // Round-robin tie with both requests held high
    ack_log.delete();
    load(0, 1'b0, 6'd1, 32'd0);
    load(1, 1'b0, 6'd2, 32'd0);
    repeat (4) run_round(1'b1, 1'b0);
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive(0, 1'b0, 1'b0, 6'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 6'd0, 32'd0);
    chk("rr_count", ack_log.size(), 32'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("rr_order%0d", k), (k < ack_log.size()) ? ack_log[k] : -1, k % 2);

    // The aborted write must not have reached the memory
    load(0, 1'b0, 6'd7, 32'd0);
    run_round(1'b0, 1'b0);
    chk("read_after_abort", last_rdata, 32'h0BADF00D);

    // Fixed priority: requester 0 always wins, requester 1 served once 0 drops
    fbus.Req0 = 1'b1; fbus.Req1 = 1'b1;
    n0 = 0; n1 = 0;
    repeat (12) begin
      @(negedge Clock);
      if (fbus.Ack0) n0++;
      if (fbus.Ack1) n1++;
    end
    chk("fix_ack0_count", n0, 32'd4);
    chk("fix_ack1_count", n1, 32'd0);
    fbus.Req0 = 1'b0;
    got = 0;
    repeat (3) begin
      @(negedge Clock);
      if (fbus.Ack1) got = 1;
    end
    chk("fix_ack1_after_drop", got, 32'd1);
    fbus.Req1 = 1'b0;

    repeat (4) @(negedge Clock);
    chk("ack_queue_drained", sq.size(), 32'd0);
    chk("mem_queue_drained", mq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
